// File: rtl/battleship_pkg.sv
// Shared constants for the ship-placement ghost: orientation codes,
// default board geometry and the scan FSM state encoding.
package battleship_pkg;

   // One-hot orientation codes
   localparam logic [3:0] NORTH = 4'b0001;
   localparam logic [3:0] EAST  = 4'b0010;
   localparam logic [3:0] SOUTH = 4'b0100;
   localparam logic [3:0] WEST  = 4'b1000;

   // Default board geometry
   localparam int DEF_GRID_W       = 10;
   localparam int DEF_GRID_H       = 10;
   localparam int DEF_TILE_LOG2    = 5;
   localparam int DEF_BANNER_TILES = 3;
   localparam int DEF_MAX_LEN      = 5;
   localparam int DEF_BLINK_FRAMES = 15;

   // Occupancy scan controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } plan_state_t;

endpackage

// File: rtl/ghost_ship_planner_if.sv
// Occupancy-RAM read bus and placement req/ack handshake of the planner.
// master = planner side, slave = RAM / input controller side.
interface ghost_ship_planner_if;
   import battleship_pkg::*;

   logic       occ_rd;
   logic [7:0] occ_addr;
   logic       occ_data;
   logic       place_req;
   logic       place_ack;
   logic       place_ok;

   modport master (
      output occ_rd, occ_addr, place_ack, place_ok,
      input  occ_data, place_req
   );

   modport slave (
      input  occ_rd, occ_addr, place_ack, place_ok,
      output occ_data, place_req
   );

endinterface

// File: rtl/ship_footprint.sv
// Combinational ship footprint: clipped bounding box, off-board end
// detection, input legality and the tile address of scan step i.
module ship_footprint
   import battleship_pkg::*;
#(
   parameter int GRID_W  = DEF_GRID_W,
   parameter int GRID_H  = DEF_GRID_H,
   parameter int MAX_LEN = DEF_MAX_LEN
) (
   input  logic [7:0] anchor_i,
   input  logic [3:0] orient_i,
   input  logic [3:0] len_i,
   input  logic [3:0] step_i,
   output logic [3:0] x_min_o,
   output logic [3:0] x_max_o,
   output logic [3:0] y_min_o,
   output logic [3:0] y_max_o,
   output logic       oob_o,
   output logic       legal_o,
   output logic [7:0] step_addr_o
);

   localparam logic signed [5:0] GW = 6'(GRID_W);
   localparam logic signed [5:0] GH = 6'(GRID_H);
   localparam logic [3:0]        ML = 4'(MAX_LEN);

   logic signed [5:0] ax, ay, span, ex, ey;
   logic signed [5:0] lo_x, hi_x, lo_y, hi_y;
   logic [3:0]        sx, sy;

   assign ax   = $signed({2'b00, anchor_i[7:4]});
   assign ay   = $signed({2'b00, anchor_i[3:0]});
   assign span = $signed({2'b00, len_i}) - 6'sd1;

   // Unclipped far end (signed, no wrap) and the address of step i
   always_comb begin
      ex = ax;
      ey = ay;
      sx = anchor_i[7:4];
      sy = anchor_i[3:0];
      case (orient_i)
         NORTH: begin ey = ay - span; sy = anchor_i[3:0] - step_i; end
         EAST:  begin ex = ax + span; sx = anchor_i[7:4] + step_i; end
         SOUTH: begin ey = ay + span; sy = anchor_i[3:0] + step_i; end
         WEST:  begin ex = ax - span; sx = anchor_i[7:4] - step_i; end
         default: ;
      endcase
   end

   assign lo_x = (ex < ax) ? ex : ax;
   assign hi_x = (ex < ax) ? ax : ex;
   assign lo_y = (ey < ay) ? ey : ay;
   assign hi_y = (ey < ay) ? ay : ey;

   assign x_min_o = (lo_x < 6'sd0) ? 4'd0 : lo_x[3:0];
   assign y_min_o = (lo_y < 6'sd0) ? 4'd0 : lo_y[3:0];
   assign x_max_o = (hi_x > GW - 6'sd1) ? 4'(GRID_W - 1) : hi_x[3:0];
   assign y_max_o = (hi_y > GH - 6'sd1) ? 4'(GRID_H - 1) : hi_y[3:0];

   assign oob_o   = (ex < 6'sd0) || (ex >= GW) || (ey < 6'sd0) || (ey >= GH);
   assign legal_o = $onehot(orient_i) && (len_i != 4'd0) && (len_i <= ML)
                    && (ax < GW) && (ay < GH);

   assign step_addr_o = {sx, sy};

endmodule

// File: rtl/ghost_ship_planner.sv
// Ship-placement ghost: draws the candidate footprint into the pixel
// stream, scans the occupancy RAM for collisions and answers placement
// requests. Optional blinking of an illegal ghost: GHOST_BLINK_EN.
module ghost_ship_planner
   import battleship_pkg::*;
#(
   parameter int GRID_W       = DEF_GRID_W,
   parameter int GRID_H       = DEF_GRID_H,
   parameter int TILE_LOG2    = DEF_TILE_LOG2,
   parameter int BANNER_TILES = DEF_BANNER_TILES,
   parameter int MAX_LEN      = DEF_MAX_LEN,
   parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   input  logic                  frame_tick,
   input  logic [7:0]            cursor,
   input  logic [3:0]            orientation,
   input  logic [3:0]            length,
   ghost_ship_planner_if.master  bus,
   output logic                  ghost_ship,
   output logic                  ghost_valid
);

   plan_state_t state_q;
   logic [7:0]  sh_cursor_q;
   logic [3:0]  sh_orient_q, sh_len_q, idx_q;
   logic        primed_q, hit_q, rd_pend_q, occ_rd_q, req_pend_q;
   logic        ack_q, ok_q, valid_q, ghost_ship_q;
   logic [7:0]  occ_addr_q;

   logic [3:0]  fp_x_min, fp_x_max, fp_y_min, fp_y_max;
   logic        live_oob, live_legal, sc_oob, sc_legal;
   logic [7:0]  sc_addr;
   logic [7:0]  unused_live_addr;
   logic [3:0]  unused_sx_min, unused_sx_max, unused_sy_min, unused_sy_max;
   logic        change, pending, final_valid, show, in_fp, on_board;
   logic [9:0]  tile_x;
   logic signed [10:0] tile_y;

   // Live inputs: drawn footprint and change-time legality decision
   ship_footprint #(.GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN)) u_fp_live (
      .anchor_i(cursor), .orient_i(orientation), .len_i(length), .step_i(4'd0),
      .x_min_o(fp_x_min), .x_max_o(fp_x_max), .y_min_o(fp_y_min), .y_max_o(fp_y_max),
      .oob_o(live_oob), .legal_o(live_legal), .step_addr_o(unused_live_addr)
   );

   // Shadow copy: scan addresses and the published verdict
   ship_footprint #(.GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_LEN(MAX_LEN)) u_fp_scan (
      .anchor_i(sh_cursor_q), .orient_i(sh_orient_q), .len_i(sh_len_q), .step_i(idx_q),
      .x_min_o(unused_sx_min), .x_max_o(unused_sx_max),
      .y_min_o(unused_sy_min), .y_max_o(unused_sy_max),
      .oob_o(sc_oob), .legal_o(sc_legal), .step_addr_o(sc_addr)
   );

   // Before the first scan the shadow is treated as stale
   assign change  = !primed_q || ({cursor, orientation, length} != {sh_cursor_q, sh_orient_q, sh_len_q});
   assign pending = req_pend_q || bus.place_req;
   // The last read's data arrives in DONE and is folded in directly
   assign final_valid = !(hit_q || (rd_pend_q && bus.occ_data)) && !sc_oob && sc_legal;

   assign tile_x   = pixel_x >> TILE_LOG2;
   assign tile_y   = $signed({1'b0, pixel_y >> TILE_LOG2}) - $signed(11'(BANNER_TILES));
   assign on_board = (tile_x < 10'(GRID_W)) && (tile_y >= 11'sd0)
                     && (tile_y < $signed(11'(GRID_H)));
   assign in_fp    = on_board && live_legal
                     && (tile_x >= {6'd0, fp_x_min}) && (tile_x <= {6'd0, fp_x_max})
                     && (tile_y >= $signed({7'd0, fp_y_min}))
                     && (tile_y <= $signed({7'd0, fp_y_max}));

`ifdef GHOST_BLINK_EN
   logic [7:0] blink_cnt_q;
   logic       blink_off_q;

   // Blink phase: toggles every BLINK_FRAMES frame ticks, restarts on input change
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt_q <= 8'd0;
         blink_off_q <= 1'b0;
      end else if (change) begin
         blink_cnt_q <= 8'd0;
         blink_off_q <= 1'b0;
      end else if (frame_tick) begin
         if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
            blink_cnt_q <= 8'd0;
            blink_off_q <= ~blink_off_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 8'd1;
         end
      end
   end

   assign show = valid_q || !blink_off_q;
`else
   logic unused_blink;
   assign unused_blink = frame_tick ^ (BLINK_FRAMES > 0);
   assign show = 1'b1;
`endif

   // Pixel path: one register stage from pixel coordinates to ghost_ship
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ghost_ship_q <= 1'b0;
      else      ghost_ship_q <= in_fp && show;
   end

   // Scan controller, request bookkeeping and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         sh_cursor_q <= 8'd0;
         sh_orient_q <= 4'd0;
         sh_len_q    <= 4'd0;
         idx_q       <= 4'd0;
         primed_q    <= 1'b0;
         hit_q       <= 1'b0;
         rd_pend_q   <= 1'b0;
         occ_rd_q    <= 1'b0;
         occ_addr_q  <= 8'd0;
         req_pend_q  <= 1'b0;
         ack_q       <= 1'b0;
         ok_q        <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         ack_q     <= 1'b0;
         occ_rd_q  <= 1'b0;
         rd_pend_q <= occ_rd_q;
         if (bus.place_req) req_pend_q <= 1'b1;
         if (change) begin
            // New (or first) candidate: abort anything in flight and restart
            sh_cursor_q <= cursor;
            sh_orient_q <= orientation;
            sh_len_q    <= length;
            primed_q    <= 1'b1;
            hit_q       <= 1'b0;
            valid_q     <= 1'b0;
            idx_q       <= 4'd0;
            rd_pend_q   <= 1'b0;
            state_q     <= (live_legal && !live_oob) ? ST_SCAN : ST_DONE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (pending) begin
                     ack_q      <= 1'b1;
                     ok_q       <= valid_q;
                     req_pend_q <= 1'b0;
                  end
               end
               ST_SCAN: begin
                  occ_rd_q   <= 1'b1;
                  occ_addr_q <= sc_addr;
                  if (rd_pend_q && bus.occ_data) hit_q <= 1'b1;
                  idx_q <= idx_q + 4'd1;
                  if (idx_q == sh_len_q - 4'd1) state_q <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (rd_pend_q && bus.occ_data) hit_q <= 1'b1;
                  state_q <= ST_DONE;
               end
               ST_DONE: begin
                  valid_q <= final_valid;
                  if (pending) begin
                     ack_q      <= 1'b1;
                     ok_q       <= final_valid;
                     req_pend_q <= 1'b0;
                  end
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.occ_rd    = occ_rd_q;
   assign bus.occ_addr  = occ_addr_q;
   assign bus.place_ack = ack_q;
   assign bus.place_ok  = ok_q;
   assign ghost_ship    = ghost_ship_q;
   assign ghost_valid   = valid_q;

endmodule

// File: tb/tb_ghost_ship_planner.sv
// Directed bench for ghost_ship_planner: occupancy RAM model, cycle-exact
// scan checks, and a scoreboard of expected place_ok values popped on ack.
module tb_ghost_ship_planner;
   import battleship_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] pixel_x = 10'd0, pixel_y = 10'd0;
   logic       frame_tick = 1'b0;
   logic [7:0] cursor;
   logic [3:0] orientation, length;
   logic       ghost_ship, ghost_valid;

   ghost_ship_planner_if bus();

   int checks = 0, failures = 0, ack_cnt = 0;
   bit         exp_q[$];
   logic [7:0] rd_log[$];
   logic       mem [256];

   always #5 clk = ~clk;

   ghost_ship_planner #(.BLINK_FRAMES(2)) dut (
      .clk(clk), .rst(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .frame_tick(frame_tick), .cursor(cursor), .orientation(orientation),
      .length(length), .bus(bus.master), .ghost_ship(ghost_ship),
      .ghost_valid(ghost_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Occupancy RAM: data valid the cycle after the read strobe
   always @(posedge clk) begin
      if (bus.occ_rd) begin
         bus.occ_data <= mem[bus.occ_addr];
         rd_log.push_back(bus.occ_addr);
      end else begin
         bus.occ_data <= 1'b0;
      end
   end

   // Scoreboard: each ack pops one expected place_ok
   always @(negedge clk) begin
      if (bus.place_ack) begin
         bit has;
         bit e;
         has = (exp_q.size() != 0);
         ack_cnt++;
         check("ack_expected", has, 1);
         if (has) begin
            e = exp_q.pop_front();
            $display("ack place_ok=%0d expected=%0d", bus.place_ok, e);
            check("place_ok", bus.place_ok, e);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] c, input logic [3:0] o, input logic [3:0] l);
      cursor = c;
      orientation = o;
      length = l;
   endtask

   task automatic pix(input string tag, input int x, input int y, input logic e);
      pixel_x = 10'(x);
      pixel_y = 10'(y);
      step();
      check(tag, ghost_ship, e);
   endtask

   task automatic do_req(input string tag, input bit e);
      exp_q.push_back(e);
      bus.place_req = 1'b1;
      step();
      bus.place_req = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      check(tag, exp_q.size(), 0);
   endtask

   task automatic settle(input int n);
      repeat (n) step();
   endtask

   initial begin
      bit exp_show;
      int acks0;
      for (int i = 0; i < 256; i++) mem[i] = 1'b0;
      bus.place_req = 1'b0;
      drive(8'h44, EAST, 4'd3);

      // Reset state
      settle(3);
      check("rst_valid", ghost_valid, 0);
      check("rst_ship", ghost_ship, 0);
      check("rst_ack", bus.place_ack, 0);
      check("rst_occ_rd", bus.occ_rd, 0);
      check("rst_occ_addr", bus.occ_addr, 0);

      // T1: first scan after release, 0x44 EAST len 3
      rst_n = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         step();
         check($sformatf("t1_rd_%0d", k), bus.occ_rd, (k >= 1 && k <= 3));
         if (k >= 1 && k <= 3)
            check($sformatf("t1_addr_%0d", k), bus.occ_addr, 8'h44 + 8'(16 * (k - 1)));
         check($sformatf("t1_valid_%0d", k), ghost_valid, (k >= 5));
      end
      pix("t1_pix_in", 160, 224, 1'b1);
      pix("t1_pix_out", 224, 224, 1'b0);
      do_req("t1_req", 1'b1);

      // Illegal inputs
      drive(8'h44, 4'b0011, 4'd3);
      settle(4);
      check("ill_ori_valid", ghost_valid, 0);
      pix("ill_ori_pix", 160, 224, 1'b0);
      do_req("ill_ori_req", 1'b0);
      drive(8'h44, EAST, 4'd6);
      settle(10);
      check("ill_len_valid", ghost_valid, 0);
      pix("ill_len_pix", 160, 224, 1'b0);
      drive(8'hA4, EAST, 4'd2);
      settle(4);
      check("ill_anchor_valid", ghost_valid, 0);
      do_req("ill_anchor_req", 1'b0);

      // T2: off-board end, drawn part clipped to x=8..9 on row 1
      rd_log.delete();
      drive(8'h81, EAST, 4'd4);
      settle(8);
      check("t2_no_rd", rd_log.size(), 0);
      check("t2_valid", ghost_valid, 0);
      pix("t2_pix_x8", 256, 128, 1'b1);
      pix("t2_pix_x9", 288, 128, 1'b1);
      pix("t2_pix_x7", 224, 128, 1'b0);
      do_req("t2_req", 1'b0);

      // T3: collision on the last tile of the scan
      mem[8'h24] = 1'b1;
      rd_log.delete();
      drive(8'h22, SOUTH, 4'd3);
      settle(8);
      check("t3_valid", ghost_valid, 0);
      check("t3_rd_cnt", rd_log.size(), 3);
      check("t3_rd_last", rd_log[2], 8'h24);
      do_req("t3_req", 1'b0);

      // T4: input change during the second scan cycle
      mem[8'h54] = 1'b1;
      rd_log.delete();
      drive(8'h44, EAST, 4'd3);
      step();
      step();
      cursor = 8'h45;
      for (int k = 2; k <= 9; k++) begin
         step();
         check($sformatf("t4_valid_%0d", k), ghost_valid, (k >= 7));
      end
      check("t4_rd_cnt", rd_log.size(), 4);
      check("t4_rd0", rd_log[0], 8'h44);
      check("t4_rd1", rd_log[1], 8'h45);
      check("t4_rd3", rd_log[3], 8'h65);

      // T5: requests during a scan, merged into one ack after DONE
      acks0 = ack_cnt;
      drive(8'h46, EAST, 4'd3);
      step();
      exp_q.push_back(1'b1);
      bus.place_req = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         bus.place_req = (k == 2);
         check($sformatf("t5_ack_%0d", k), bus.place_ack, (k == 5));
      end
      settle(4);
      check("t5_ack_once", ack_cnt - acks0, 1);
      check("t5_sb_empty", exp_q.size(), 0);

      // NORTH ending on row 0, and a pixel above the board
      rd_log.delete();
      drive(8'h92, NORTH, 4'd3);
      settle(8);
      check("n_valid", ghost_valid, 1);
      check("n_rd_last", rd_log[2], 8'h90);
      pix("n_pix_row0", 293, 96, 1'b1);
      pix("n_pix_banner", 293, 64, 1'b0);

      // WEST running off the left edge, clipped to x=0..1 on row 3
      rd_log.delete();
      drive(8'h13, WEST, 4'd4);
      settle(6);
      check("w_no_rd", rd_log.size(), 0);
      check("w_valid", ghost_valid, 0);
      pix("w_pix_x0", 0, 192, 1'b1);
      pix("w_pix_x2", 64, 192, 1'b0);

      // T6: frame ticks on an illegal ghost
      drive(8'h81, EAST, 4'd4);
      pixel_x = 10'd256;
      pixel_y = 10'd128;
      settle(4);
      for (int n = 1; n <= 6; n++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
`ifdef GHOST_BLINK_EN
         exp_show = (((n / 2) % 2) == 0);
`else
         exp_show = 1'b1;
`endif
         check($sformatf("t6_blink_%0d", n), ghost_ship, exp_show);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
